pipeline_stall_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline: drives the per-stage load-enable and bubble/flush

---
 rtl/pipeline_stall_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer.
// Produces the per-stage load enables and bubble/flush controls for
// PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It also runs the data-memory wait
// with a timeout, a saturating stall-cycle counter and a sticky timeout flag.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_BOOT     | one cycle after reset, pipeline held with NOPs in place
//   ST_RUN      | normal flow; load-use stall and taken-branch flush
//   ST_MEM_WAIT | data access in flight, pipeline frozen until mem_ack_i
//   ST_HALT     | access timed out; frozen until rst_i
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             mem_start_o,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             mem_wb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o
);

  // Timer only has to reach MEM_TIMEOUT-1 before the HALT decision.
  localparam int unsigned TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_q, to_d;

  // Stage controls: decoded from current state and this cycle's events.
  always_comb begin
    mem_start_o     = 1'b0;
    pc_en_o         = 1'b0;
    if_id_en_o      = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_en_o      = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_en_o     = 1'b0;
    mem_wb_en_o     = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (rst_i || state_q == ST_BOOT) begin
      if_id_flush_o   = 1'b1;
      id_ex_bubble_o  = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_req_i) begin
            // Freeze everything upstream; MEM_WB keeps loading a bubble so the
            // instruction ahead of the access retires exactly once.
            mem_start_o     = 1'b1;
            mem_wb_en_o     = 1'b1;
            mem_wb_bubble_o = 1'b1;
          end else if (load_use_i) begin
            // Branch is ignored here; it re-resolves once the load result exists.
            id_ex_en_o     = 1'b1;
            id_ex_bubble_o = 1'b1;
            ex_mem_en_o    = 1'b1;
            mem_wb_en_o    = 1'b1;
          end else begin
            pc_en_o       = 1'b1;
            if_id_en_o    = 1'b1;
            id_ex_en_o    = 1'b1;
            ex_mem_en_o   = 1'b1;
            mem_wb_en_o   = 1'b1;
            if_id_flush_o = branch_taken_i;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i) begin
            pc_en_o     = 1'b1;
            if_id_en_o  = 1'b1;
            id_ex_en_o  = 1'b1;
            ex_mem_en_o = 1'b1;
            mem_wb_en_o = 1'b1;
          end else begin
            mem_wb_en_o     = 1'b1;
            mem_wb_bubble_o = 1'b1;
          end
        end
        ST_HALT: mem_wb_bubble_o = 1'b1;
        default: mem_wb_bubble_o = 1'b1;
      endcase
    end
  end

  // Next state, access timer, stall counter and sticky timeout.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (mem_req_i) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          tmr_d   = '0;
          state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
          if (tmr_q == TMR_LAST) begin
            state_d = ST_HALT;
            to_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
    if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !pc_en_o && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_BOOT;
      tmr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign stall_cnt_o = cnt_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a cycle-level model.
module tb_pipeline_stall_ctrl;

  localparam int MT    = 8;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          load_use_i = 1'b0, branch_taken_i = 1'b0, mem_req_i = 1'b0, mem_ack_i = 1'b0;
  logic          mem_start_o, pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_bubble_o;
  logic          ex_mem_en_o, mem_wb_en_o, mem_wb_bubble_o, timeout_o;
  logic [CW-1:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model state
  int m_mode  = M_BOOT;
  int m_waits = 0;
  int m_cnt   = 0;
  int m_to    = 0;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_use_i(load_use_i), .branch_taken_i(branch_taken_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .mem_start_o(mem_start_o), .pc_en_o(pc_en_o),
    .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_en_o(id_ex_en_o), .id_ex_bubble_o(id_ex_bubble_o),
    .ex_mem_en_o(ex_mem_en_o), .mem_wb_en_o(mem_wb_en_o),
    .mem_wb_bubble_o(mem_wb_bubble_o),
    .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stage controls from the operating mode and current events.
  task automatic expect_out(output bit st, output bit pc, output bit ifen, output bit ifl,
                            output bit idex, output bit idb, output bit exm, output bit mwb,
                            output bit mwbb);
    {st, pc, ifen, ifl, idex, idb, exm, mwb, mwbb} = '0;
    if (rst_i || m_mode == M_BOOT) begin
      ifl = 1; idb = 1; mwbb = 1;
    end else if (m_mode == M_HALT) begin
      mwbb = 1;
    end else if (m_mode == M_RUN) begin
      if (mem_req_i) begin
        st = 1; mwb = 1; mwbb = 1;
      end else begin
        pc = !load_use_i; ifen = !load_use_i;
        idex = 1; idb = load_use_i; exm = 1; mwb = 1;
        ifl = branch_taken_i && !load_use_i;
      end
    end else begin
      if (mem_ack_i) begin
        pc = 1; ifen = 1; idex = 1; exm = 1; mwb = 1;
      end else begin
        mwb = 1; mwbb = 1;
      end
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk_i) begin
    bit st, pc, ifen, ifl, idex, idb, exm, mwb, mwbb;
    if (chk_en) begin
      expect_out(st, pc, ifen, ifl, idex, idb, exm, mwb, mwbb);
      chk("mem_start",     int'(mem_start_o),     int'(st));
      chk("pc_en",         int'(pc_en_o),         int'(pc));
      chk("if_id_en",      int'(if_id_en_o),      int'(ifen));
      chk("if_id_flush",   int'(if_id_flush_o),   int'(ifl));
      chk("id_ex_en",      int'(id_ex_en_o),      int'(idex));
      chk("id_ex_bubble",  int'(id_ex_bubble_o),  int'(idb));
      chk("ex_mem_en",     int'(ex_mem_en_o),     int'(exm));
      chk("mem_wb_en",     int'(mem_wb_en_o),     int'(mwb));
      chk("mem_wb_bubble", int'(mem_wb_bubble_o), int'(mwbb));
      chk("stall_cnt",     int'(stall_cnt_o),     m_cnt);
      chk("timeout",       int'(timeout_o),       m_to);
    end
  end

  // Model advance: one step per clock.
  always @(posedge clk_i) begin
    bit stalled;
    if (rst_i) begin
      m_mode = M_BOOT; m_waits = 0; m_cnt = 0; m_to = 0;
    end else begin
      stalled = (m_mode == M_RUN && (mem_req_i || load_use_i)) ||
                (m_mode == M_WAIT && !mem_ack_i);
      if (stalled && m_cnt < CMAX) m_cnt = m_cnt + 1;
      case (m_mode)
        M_BOOT: m_mode = M_RUN;
        M_RUN:  if (mem_req_i) begin m_mode = M_WAIT; m_waits = 0; end
        M_WAIT: begin
          if (mem_ack_i) m_mode = M_RUN;
          else begin
            m_waits = m_waits + 1;
            if (m_waits == MT) begin m_mode = M_HALT; m_to = 1; end
          end
        end
        default: m_mode = M_HALT;
      endcase
    end
  end

  task automatic set_in(input bit r, input bit lu, input bit br, input bit mr, input bit ak);
    rst_i = r; load_use_i = lu; branch_taken_i = br; mem_req_i = mr; mem_ack_i = ak;
    #1;
  endtask

  task automatic tick();
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int ack_pct;
    @(posedge clk_i); #1;
    chk_en = 1'b1;

    // reset held two cycles
    set_in(1, 0, 0, 0, 0);
    chk("rst pc_en", int'(pc_en_o), 0);
    chk("rst id_ex_bubble", int'(id_ex_bubble_o), 1);
    tick(); tick();
    chk("rst cnt", int'(stall_cnt_o), 0);
    chk("rst timeout", int'(timeout_o), 0);

    // BOOT cycle, then RUN
    set_in(0, 0, 0, 0, 0);
    chk("boot pc_en", int'(pc_en_o), 0);
    chk("boot flush", int'(if_id_flush_o), 1);
    tick();
    chk("run pc_en", int'(pc_en_o), 1);
    chk("run if_id_en", int'(if_id_en_o), 1);
    tick();

    // single load-use
    set_in(0, 1, 0, 0, 0);
    chk("lu pc_en", int'(pc_en_o), 0);
    chk("lu id_ex_en", int'(id_ex_en_o), 1);
    chk("lu id_ex_bubble", int'(id_ex_bubble_o), 1);
    tick();
    chk("lu cnt", int'(stall_cnt_o), 1);
    set_in(0, 0, 0, 0, 0);
    chk("after lu pc_en", int'(pc_en_o), 1);
    chk("after lu bubble", int'(id_ex_bubble_o), 0);
    tick();

    // load-use and branch together
    set_in(0, 1, 1, 0, 0);
    chk("lu+br flush", int'(if_id_flush_o), 0);
    chk("lu+br pc_en", int'(pc_en_o), 0);
    tick();
    chk("lu+br cnt", int'(stall_cnt_o), 2);
    set_in(0, 0, 1, 0, 0);
    chk("br flush", int'(if_id_flush_o), 1);
    chk("br pc_en", int'(pc_en_o), 1);
    tick();

    // access with ack three cycles after the request
    set_in(0, 0, 0, 1, 0);
    chk("req start", int'(mem_start_o), 1);
    chk("req mwb_bubble", int'(mem_wb_bubble_o), 1);
    chk("req pc_en", int'(pc_en_o), 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("wait start", int'(mem_start_o), 0);
    chk("wait mwb_en", int'(mem_wb_en_o), 1);
    tick(); tick();
    set_in(0, 1, 1, 0, 1);
    chk("ack pc_en", int'(pc_en_o), 1);
    chk("ack mwb_bubble", int'(mem_wb_bubble_o), 0);
    chk("ack ignores branch", int'(if_id_flush_o), 0);
    tick();
    chk("mem cnt", int'(stall_cnt_o), 5);
    set_in(0, 0, 0, 0, 0);
    tick();

    // timeout into HALT
    set_in(0, 0, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    repeat (MT - 1) tick();
    chk("pre-timeout flag", int'(timeout_o), 0);
    tick();
    chk("timeout flag", int'(timeout_o), 1);
    set_in(0, 1, 1, 1, 1);
    chk("halt pc_en", int'(pc_en_o), 0);
    chk("halt start", int'(mem_start_o), 0);
    chk("halt mwb_en", int'(mem_wb_en_o), 0);
    repeat (4) tick();
    chk("halt sticky", int'(timeout_o), 1);
    chk("halt cnt", int'(stall_cnt_o), 14);

    // reset during MEM_WAIT, stray ack in BOOT
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1);
    chk("stray ack start", int'(mem_start_o), 0);
    chk("stray ack pc_en", int'(pc_en_o), 0);
    tick();
    chk("stray ack run pc_en", int'(pc_en_o), 1);
    chk("stray ack start run", int'(mem_start_o), 0);
    tick();
    chk("post-rst cnt", int'(stall_cnt_o), 0);
    chk("post-rst timeout", int'(timeout_o), 0);

    // counter saturation
    set_in(0, 1, 0, 0, 0);
    repeat (CMAX + 7) tick();
    chk("cnt saturate", int'(stall_cnt_o), CMAX);
    set_in(0, 0, 0, 0, 0);
    tick();

    // randomized traffic
    ack_pct = 40;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 4;
          1: ack_pct = 40;
          default: ack_pct = 90;
        endcase
      end
      set_in($urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 25,
             $urandom_range(0, 99) < 25,
             $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < ack_pct);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
